ofifo_drain: RTL
================

// Module: ofifo_drain
// PURPOSE
//  Reader for the corelet OFIFO write side. Pops psum vectors (col x psum_bw) whenever ofifo_valid is high.
//  Writes each vector to consecutive addresses of the single-port psum SRAM (active-low CEN/WEN, 1-cycle read latency).
//  Optional accumulate mode adds each vector onto the stored word (read-modify-write).
//  Sits between corelet.ofifo_* and the psum SRAM; the top-level sequencer drives start/len.
// PARAMETERS
//  col      8   PE columns (psum words per vector)
//  psum_bw  16  bits per psum word
//  addr_bw  4   psum SRAM address width
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high reset
//  start        in   1            1-cycle pulse; latches base_addr/num_vec/acc_mode; ignored while busy
//  base_addr    in   addr_bw      first SRAM address
//  num_vec      in   addr_bw+1    vectors to drain (0 allowed)
//  acc_mode     in   1            1 = read-modify-write (only with OFIFO_DRAIN_ACC_EN, else ignored)
//  ofifo_valid  in   1            OFIFO holds a complete vector
//  ofifo_out    in   col*psum_bw  OFIFO head vector, valid same cycle as ofifo_valid (first-word-fall-through)
//  ofifo_rd     out  1            pop strobe (combinational)
//  psum_cen     out  1            SRAM chip enable, active-low (registered)
//  psum_wen     out  1            SRAM write enable, active-low (registered)
//  psum_addr    out  addr_bw      SRAM address (registered)
//  psum_d       out  col*psum_bw  SRAM write data (registered)
//  psum_q       in   col*psum_bw  SRAM read data, valid 1 cycle after read edge
//  busy         out  1            job in progress
//  done         out  1            1-cycle pulse at job end
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, ofifo_rd=0, psum_cen=1, psum_wen=1, psum_addr=0, psum_d=0, counters=0.
//  FSM states: IDLE, DRAIN, RD_WAIT, ACC_WR, DONE.
//  IDLE: on start, go to DRAIN, latch job, cnt=0, busy=1. If num_vec==0, go directly to DONE.
//  DRAIN: ofifo_rd = ofifo_valid & (cnt<num_vec).
//   Plain mode: on a pop, the next cycle drives cen=0, wen=0, addr=base+cnt, d=popped vector; cnt++.
//    Throughput is 1 vector/cycle. Stay in DRAIN with no pop while ofifo_valid=0.
//   Acc mode: on a pop, latch the vector; the next cycle drives cen=0, wen=1, addr=base+cnt; go to RD_WAIT.
//  RD_WAIT: cen=1; psum_q is valid in the following cycle; go to ACC_WR.
//  ACC_WR: cen=0, wen=0, same addr, d = per-column sum(psum_q, latched); cnt++; return to DRAIN.
//   Acc-mode throughput is 1 vector per 3 cycles; no pop during RD_WAIT or ACC_WR.
//  The last write goes to DONE (cycle after final write issue). DONE: done=1, busy=0 -> IDLE.
//  Arithmetic: per-column signed two's complement, result truncated to psum_bw (wraps, no saturation).
//  Address: base+cnt wraps modulo 2^addr_bw.
//  cen is high on every cycle without an access. Never more than num_vec pops per job.
//  start while busy: ignored, latched job unchanged. start in the DONE cycle: ignored.
//  Reset mid-job: go to IDLE immediately. An in-flight popped vector is discarded and no write is issued on the next cycle.
// CONFIGURATION
//  `OFIFO_DRAIN_ACC_EN defined: acc_mode honoured; RD_WAIT/ACC_WR and the adder are built.
//  Not defined: acc_mode ignored; plain write-through only; psum_q unused; the states are never entered.
// STRUCTURE
//  Shared header corelet_defs.vh: FSM state localparams (3-bit), default col/psum_bw/addr_bw.
//  Sub-module psum_col_adder (col lanes, psum_bw, combinational, wrapping), instantiated only under the macro.
// TESTING
//  1 plain: base=2, num=3, ofifo_valid held 1, vectors V0..V2
//    -> 3 pops on consecutive cycles; writes to addr 2,3,4 with V0..V2; done 1 cycle after the write to 4.
//  2 stall: num=2, valid toggles 1,0,0,1
//    -> exactly 2 pops and 2 writes; no cen=0 during the gap; busy stays 1 until done.
//  3 zero/wrap: num=0 -> done next cycle with no pop.
//    base=15, num=2, addr_bw=4 -> writes to addr 15 then 0.
//  4 acc (macro on): SRAM[5] lanes=100, vector lanes=-30, base=5, num=1, acc=1
//    -> read 5, then write 70 in all lanes.
//    SRAM lane 32767 + 1 -> -32768 (wrap).
//  5 reset mid-job: reset asserted the cycle after a pop
//    -> next cycle cen=1, busy=0, no write; a new start behaves as a fresh job.
//  6 start while busy with different base -> ignored; original addresses used; done count = 1.

Source files
------------

// File: rtl/ofifo_drain_pkg.sv
// ---------------------------------------------------------------------------
// ofifo_drain_pkg
//   Shared definitions for the OFIFO drain block: default geometry of the
//   psum path and the drain FSM state encoding.
//   Ports: none (package).
//   Build option: OFIFO_DRAIN_ACC_EN (see ofifo_drain.sv).
// ---------------------------------------------------------------------------
package ofifo_drain_pkg;

  localparam int COL     = 8;   // PE columns = psum words per vector
  localparam int PSUM_BW = 16;  // bits per psum word
  localparam int ADDR_BW = 4;   // psum SRAM address width

  // RD_WAIT / ACC_WR exist in every build but are only reachable when the
  // accumulate path is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_ACC_WR  = 3'd3,
    ST_DONE    = 3'd4
  } drain_state_t;

endpackage

// File: rtl/ofifo_drain_if.sv
// ---------------------------------------------------------------------------
// ofifo_drain_if
//   Bundles the OFIFO read side and the psum SRAM port seen by the drain.
//   Signals:
//     ofifo_valid / ofifo_out : OFIFO head vector (first-word-fall-through)
//     ofifo_rd                : pop strobe
//     psum_cen / psum_wen     : SRAM enables, active-low
//     psum_addr / psum_d      : SRAM address / write data
//     psum_q                  : SRAM read data, one cycle after the read edge
//   Modports:
//     master : the drain (drives ofifo_rd and the SRAM request)
//     slave  : the environment (OFIFO + SRAM)
// ---------------------------------------------------------------------------
interface ofifo_drain_if
  import ofifo_drain_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int addr_bw = ADDR_BW
);

  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_out;
  logic                     ofifo_rd;
  logic                     psum_cen;
  logic                     psum_wen;
  logic [addr_bw-1:0]       psum_addr;
  logic [col*psum_bw-1:0]   psum_d;
  logic [col*psum_bw-1:0]   psum_q;

  modport master (
    input  ofifo_valid, ofifo_out, psum_q,
    output ofifo_rd, psum_cen, psum_wen, psum_addr, psum_d
  );

  modport slave (
    output ofifo_valid, ofifo_out, psum_q,
    input  ofifo_rd, psum_cen, psum_wen, psum_addr, psum_d
  );

endinterface

// File: rtl/ofifo_drain_psum_col_adder.sv
// ---------------------------------------------------------------------------
// psum_col_adder
//   Lane-wise adder for psum vectors: col independent signed psum_bw-bit
//   additions, result wraps to psum_bw bits (no saturation). Combinational.
//   Ports:
//     a, b : input vectors  (col*psum_bw)
//     sum  : lane-wise a+b  (col*psum_bw)
// ---------------------------------------------------------------------------
module psum_col_adder #(
  parameter int col     = 8,
  parameter int psum_bw = 16
) (
  input  logic [col*psum_bw-1:0] a,
  input  logic [col*psum_bw-1:0] b,
  output logic [col*psum_bw-1:0] sum
);

  // Two's complement wrap makes signed and unsigned addition identical once
  // the carry out of each lane is dropped.
  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
      assign sum[gi*psum_bw +: psum_bw] = a[gi*psum_bw +: psum_bw] + b[gi*psum_bw +: psum_bw];
    end
  endgenerate

endmodule

// File: rtl/ofifo_drain.sv
// ---------------------------------------------------------------------------
// ofifo_drain
//   Drains psum vectors from the corelet OFIFO into consecutive addresses of
//   the single-port psum SRAM. Optional accumulate mode performs a
//   read-modify-write, adding each popped vector onto the stored word.
//   Build option: define OFIFO_DRAIN_ACC_EN to honour acc_mode; otherwise the
//   block is a plain write-through drain and psum_q is unused.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     start                 : 1-cycle job pulse (accepted only in IDLE)
//     base_addr, num_vec    : first SRAM address, vectors to drain (0 allowed)
//     acc_mode              : 1 = read-modify-write (macro builds only)
//     busy, done            : job in progress, 1-cycle end-of-job pulse
//     bus (master)          : OFIFO pop side + psum SRAM port
// ---------------------------------------------------------------------------
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int addr_bw = ADDR_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [addr_bw:0]   num_vec,
  input  logic               acc_mode,
  output logic               busy,
  output logic               done,
  ofifo_drain_if.master      bus
);

  localparam logic [addr_bw:0] CNT_ONE = (addr_bw+1)'(1);

  drain_state_t           state_reg;
  logic [addr_bw:0]       cnt_reg;
  logic [addr_bw:0]       num_reg;
  logic [addr_bw-1:0]     base_reg;
  logic                   cen_reg;
  logic                   wen_reg;
  logic [addr_bw-1:0]     addr_reg;
  logic [col*psum_bw-1:0] d_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   pop;

`ifdef OFIFO_DRAIN_ACC_EN
  logic                   acc_reg;
  logic [col*psum_bw-1:0] vec_reg;
  logic [col*psum_bw-1:0] acc_sum;

  psum_col_adder #(
    .col     (col),
    .psum_bw (psum_bw)
  ) u_adder (
    .a   (bus.psum_q),
    .b   (vec_reg),
    .sum (acc_sum)
  );
`else
  // Plain build: accumulate request and SRAM read data have no consumer.
  logic unused_in;
  assign unused_in = ^{acc_mode, bus.psum_q};
`endif

  // Pop is gated by reset so a vector is never consumed in a cycle whose
  // state is about to be thrown away.
  assign pop = (state_reg == ST_DRAIN) && bus.ofifo_valid && (cnt_reg < num_reg) && !reset;

  assign bus.ofifo_rd  = pop;
  assign bus.psum_cen  = cen_reg;
  assign bus.psum_wen  = wen_reg;
  assign bus.psum_addr = addr_reg;
  assign bus.psum_d    = d_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      num_reg   <= '0;
      base_reg  <= '0;
      cen_reg   <= 1'b1;
      wen_reg   <= 1'b1;
      addr_reg  <= '0;
      d_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef OFIFO_DRAIN_ACC_EN
      acc_reg   <= 1'b0;
      vec_reg   <= '0;
`endif
    end else begin
      // SRAM idles (cen high, read polarity) unless a state below issues an access.
      cen_reg  <= 1'b1;
      wen_reg  <= 1'b1;
      done_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            base_reg <= base_addr;
            num_reg  <= num_vec;
            cnt_reg  <= '0;
`ifdef OFIFO_DRAIN_ACC_EN
            acc_reg  <= acc_mode;
`endif
            if (num_vec == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_DRAIN;
              busy_reg  <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (pop) begin
            cen_reg  <= 1'b0;
            addr_reg <= base_reg + cnt_reg[addr_bw-1:0];
`ifdef OFIFO_DRAIN_ACC_EN
            if (acc_reg) begin
              // Read the stored word first; cnt advances on the write-back.
              vec_reg   <= bus.ofifo_out;
              state_reg <= ST_RD_WAIT;
            end else begin
              wen_reg <= 1'b0;
              d_reg   <= bus.ofifo_out;
              cnt_reg <= cnt_reg + CNT_ONE;
            end
`else
            wen_reg <= 1'b0;
            d_reg   <= bus.ofifo_out;
            cnt_reg <= cnt_reg + CNT_ONE;
`endif
          end else if (cnt_reg == num_reg) begin
            // Reached only once the final write is on the SRAM port.
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end

`ifdef OFIFO_DRAIN_ACC_EN
        ST_RD_WAIT: begin
          // Read is on the port this cycle; psum_q is valid in ACC_WR.
          state_reg <= ST_ACC_WR;
        end

        ST_ACC_WR: begin
          cen_reg   <= 1'b0;
          wen_reg   <= 1'b0;
          d_reg     <= acc_sum;
          cnt_reg   <= cnt_reg + CNT_ONE;
          state_reg <= ST_DRAIN;
        end
`endif

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
